// File: rtl/cpu_fpu_float_to_int.sv
// Single-precision float to integer converter (fcvt.w / fcvt.wu style).
//
// A request captures the operand, signedness and rounding mode, then walks a
// small multi-cycle datapath: unpack, align the significand onto the binary
// point a few bits per cycle, round, and present the result.
//
// Ports:
//   i_clock     sole clock, rising edge
//   i_reset_n   asynchronous active-low reset
//   i_request   conversion request, held high until o_ready is seen
//   i_op1       IEEE-754 single-precision operand
//   i_unsigned  1 = unsigned result, 0 = signed result
//   i_rm        rounding mode (RNE, RTZ, RDN, RUP, RMM; others act as RNE)
//   o_ready     result valid
//   o_result    registered integer result
//   o_flags     {NV, DZ, OF, UF, NX}; DZ/OF/UF are always 0
module cpu_fpu_float_to_int #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    input  logic            i_request,
    input  logic [31:0]     i_op1,
    input  logic            i_unsigned,
    input  logic [2:0]      i_rm,
    output logic            o_ready,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_flags
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StUnpack = 3'd1,
        StAlign  = 3'd2,
        StRound  = 3'd3,
        StPutZ   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       op_q, op_d;
    logic              uns_q, uns_d;
    logic [2:0]        rm_q, rm_d;
    logic [XLEN-1:0]   int_q, int_d;
    logic              r_q, r_d;
    logic              s_q, s_d;
    logic              left_q, left_d;
    logic [9:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        flags_q, flags_d;
    logic              ready_q, ready_d;

    // Operand decode
    logic              op_sign;
    logic [7:0]        op_exp;
    logic [22:0]       op_frac;
    logic signed [9:0] unb_exp;
    logic signed [9:0] lsh_cnt;
    logic signed [9:0] rsh_cnt;
    logic              exp_max;
    logic              exp_zero;
    logic              frac_zero;
    logic              is_nan;
    logic              too_big;

    assign op_sign   = op_q[31];
    assign op_exp    = op_q[30:23];
    assign op_frac   = op_q[22:0];
    assign unb_exp   = $signed({2'b00, op_exp}) - 10'sd127;
    assign lsh_cnt   = unb_exp - 10'sd23;
    assign rsh_cnt   = 10'sd23 - unb_exp;
    assign exp_max   = (op_exp == 8'hff);
    assign exp_zero  = (op_exp == 8'h00);
    assign frac_zero = (op_frac == 23'd0);
    assign is_nan    = exp_max & ~frac_zero;
    assign too_big   = (unb_exp >= $signed(10'(XLEN)));

    // Saturation value for invalid conversions
    function automatic logic [XLEN-1:0] sat_value(input logic pos, input logic uns);
        logic [XLEN-1:0] val;
        if (uns) begin
            val = pos ? {XLEN{1'b1}} : {XLEN{1'b0}};
        end else begin
            val = pos ? {1'b0, {(XLEN-1){1'b1}}} : {1'b1, {(XLEN-1){1'b0}}};
        end
        return val;
    endfunction

    // Alignment shifter: up to SHIFT_STEP single-bit shifts, bounded by the
    // remaining count. Right shifts funnel int -> R -> S, with S sticky.
    logic [XLEN-1:0] sh_int;
    logic            sh_r;
    logic            sh_s;

    always_comb begin
        sh_int = int_q;
        sh_r   = r_q;
        sh_s   = s_q;
        for (int unsigned i = 0; i < SHIFT_STEP; i++) begin
            if (10'(i) < cnt_q) begin
                if (left_q) begin
                    sh_int = {sh_int[XLEN-2:0], 1'b0};
                end else begin
                    sh_s   = sh_s | sh_r;
                    sh_r   = sh_int[0];
                    sh_int = {1'b0, sh_int[XLEN-1:1]};
                end
            end
        end
    end

    // Rounding and range check
    logic            inc;
    logic [XLEN:0]   mag;
    logic [XLEN-1:0] mag_lo;
    logic [XLEN-1:0] rounded;
    logic            range_bad;

    always_comb begin
        case (rm_q)
            3'b001:  inc = 1'b0;
            3'b010:  inc = op_sign & (r_q | s_q);
            3'b011:  inc = ~op_sign & (r_q | s_q);
            3'b100:  inc = r_q;
            default: inc = r_q & (s_q | int_q[0]);
        endcase
    end

    assign mag     = {1'b0, int_q} + (XLEN+1)'(inc);
    assign mag_lo  = mag[XLEN-1:0];
    assign rounded = op_sign ? (~mag_lo + XLEN'(1)) : mag_lo;

    always_comb begin
        if (uns_q) begin
            range_bad = op_sign ? (mag != '0) : mag[XLEN];
        end else if (op_sign) begin
            // Negative signed may reach exactly 2^(XLEN-1)
            range_bad = mag[XLEN] | (mag[XLEN-1] & (|mag[XLEN-2:0]));
        end else begin
            range_bad = mag[XLEN] | mag[XLEN-1];
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        uns_d    = uns_q;
        rm_d     = rm_q;
        int_d    = int_q;
        r_d      = r_q;
        s_d      = s_q;
        left_d   = left_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            StIdle: begin
                if (i_request) begin
                    op_d    = i_op1;
                    uns_d   = i_unsigned;
                    rm_d    = i_rm;
                    state_d = StUnpack;
                end
            end

            StUnpack: begin
                if (!i_request) begin
                    state_d = StIdle;
                end else if (exp_max || too_big) begin
                    result_d = sat_value(is_nan | ~op_sign, uns_q);
                    flags_d  = 5'b10000;
                    state_d  = StPutZ;
                end else if (exp_zero && frac_zero) begin
                    result_d = '0;
                    flags_d  = 5'b00000;
                    state_d  = StPutZ;
                end else if (exp_zero) begin
                    // Denormal: magnitude below one half, only sticky survives
                    int_d   = '0;
                    r_d     = 1'b0;
                    s_d     = 1'b1;
                    state_d = StRound;
                end else begin
                    int_d = {{(XLEN-24){1'b0}}, 1'b1, op_frac};
                    r_d   = 1'b0;
                    s_d   = 1'b0;
                    if (unb_exp > 10'sd23) begin
                        left_d  = 1'b1;
                        cnt_d   = $unsigned(lsh_cnt);
                        state_d = StAlign;
                    end else if (unb_exp < 10'sd23) begin
                        // Beyond 26 every significand bit already sits in S
                        left_d  = 1'b0;
                        cnt_d   = (rsh_cnt > 10'sd26) ? 10'd26 : $unsigned(rsh_cnt);
                        state_d = StAlign;
                    end else begin
                        state_d = StRound;
                    end
                end
            end

            StAlign: begin
                if (!i_request) begin
                    state_d = StIdle;
                end else begin
                    int_d = sh_int;
                    r_d   = sh_r;
                    s_d   = sh_s;
                    if (cnt_q <= 10'(SHIFT_STEP)) begin
                        cnt_d   = '0;
                        state_d = StRound;
                    end else begin
                        cnt_d = cnt_q - 10'(SHIFT_STEP);
                    end
                end
            end

            StRound: begin
                if (!i_request) begin
                    state_d = StIdle;
                end else begin
                    if (range_bad) begin
                        result_d = sat_value(~op_sign, uns_q);
                        flags_d  = 5'b10000;
                    end else begin
                        result_d = rounded;
                        flags_d  = {4'b0000, r_q | s_q};
                    end
                    state_d = StPutZ;
                end
            end

            StPutZ: begin
                if (!i_request) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    assign ready_d = (state_d == StPutZ);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            uns_q    <= 1'b0;
            rm_q     <= '0;
            int_q    <= '0;
            r_q      <= 1'b0;
            s_q      <= 1'b0;
            left_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            uns_q    <= uns_d;
            rm_q     <= rm_d;
            int_q    <= int_d;
            r_q      <= r_d;
            s_q      <= s_d;
            left_q   <= left_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            ready_q  <= ready_d;
        end
    end

    assign o_ready  = ready_q;
    assign o_result = result_q;
    assign o_flags  = flags_q;

endmodule

// File: doc/cpu_fpu_float_to_int.md
CPU_FPU_FLOAT_TO_INT -- requirements
Module: cpu_fpu_float_to_int

Interface
REQ-001 SHALL have parameter XLEN, default 32, result width; legal values 32, 64.
REQ-002 SHALL have parameter SHIFT_STEP, default 1, alignment bits shifted per cycle; legal values 1, 2, 4, 8.
REQ-003 i_clock  input  1  sole clock; all state updates on rising edge.
REQ-004 i_reset_n  input  1  reset; asynchronous, active-low.
REQ-005 i_request  input  1  conversion request; held high until o_ready is seen.
REQ-006 i_op1  input  32  IEEE-754 single-precision operand.
REQ-007 i_unsigned  input  1  1 = convert to unsigned (fcvt.wu), 0 = signed (fcvt.w).
REQ-008 i_rm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE, no flag.
REQ-009 o_ready  output  1  result valid.
REQ-010 o_result  output  XLEN  integer result, registered.
REQ-011 o_flags  output  5  {NV,DZ,OF,UF,NX}; DZ, OF, UF always 0.

Function
REQ-012 States: IDLE, UNPACK, ALIGN, ROUND, PUT_Z; unused encodings return to IDLE.
REQ-013 IDLE: on i_request=1 capture i_op1, i_unsigned, i_rm; go to UNPACK; later input changes ignored until IDLE.
REQ-014 UNPACK: E = biased exponent - 127; NaN, +/-inf, or E >= XLEN go directly to PUT_Z with invalid result (REQ-019); zero goes to PUT_Z with 0, no flags.
REQ-015 Working register W = XLEN integer bits + round bit R + sticky bit S; load integer part = {1,frac} (denormal: integer 0, R=0, S=1, skip ALIGN).
REQ-016 ALIGN: E>23: shift W left E-23 bits; E<23: shift right 23-E bits, OR every bit shifted past R into S; right-shift count saturates at 26; at most SHIFT_STEP bits per cycle; ALIGN cycles = ceil(count/SHIFT_STEP), zero cycles when count is 0.
REQ-017 ROUND: increment = RNE R&(S|L), RTZ 0, RDN sign&(R|S), RUP !sign&(R|S), RMM R (L = integer LSB); magnitude = integer + increment, computed at XLEN+1 bits.
REQ-018 Range after rounding: signed allows magnitude <= 2^(XLEN-1)-1 positive, <= 2^(XLEN-1) negative; unsigned allows <= 2^XLEN-1 positive, only 0 when negative.
REQ-019 Invalid (NaN, inf, out of range): NaN or positive -> signed 2^(XLEN-1)-1 / unsigned all-ones; negative -> signed 2^(XLEN-1) (MSB only) / unsigned 0; NV=1, NX=0.
REQ-020 Valid result: sign ? two's-complement negate : magnitude; NX = R|S; NV=0.
REQ-021 PUT_Z: o_ready=1, o_result/o_flags updated; stay while i_request=1; on i_request=0 drop o_ready next edge and go to IDLE.
REQ-022 i_request deasserted in UNPACK, ALIGN or ROUND: abort to IDLE next edge; o_ready stays 0; o_result/o_flags unchanged.
REQ-023 o_result/o_flags hold last value from PUT_Z until the next PUT_Z entry.
REQ-024 Latency from request-sample edge to o_ready=1: 3 + ALIGN cycles (SHIFT_STEP=1, pi: 3+22=25).

Reset
REQ-025 i_reset_n=0 SHALL immediately, without clock, force state IDLE, o_ready=0, o_result=0, o_flags=0, in any state.
REQ-026 After i_reset_n release with i_request high, a new conversion SHALL start from a fresh capture on the next edge.

Verification
REQ-027 XLEN=32, 0x40490FDB, signed, RNE -> 0x00000003, flags 0x01; o_ready at cycle 25 (SHIFT_STEP=1), cycle 9 (SHIFT_STEP=4).
REQ-028 0xC0200000 (-2.5), signed: RNE -> 0xFFFFFFFE, RTZ -> 0xFFFFFFFE, RUP -> 0xFFFFFFFE, RDN -> 0xFFFFFFFD, RMM -> 0xFFFFFFFD; all flags 0x01.
REQ-029 0x4F000000 (2^31): signed -> 0x7FFFFFFF flags 0x10; unsigned -> 0x80000000 flags 0x00; 0x7FC00000 unsigned -> 0xFFFFFFFF flags 0x10; 0xFF800000 unsigned -> 0 flags 0x10; 0xBF000000 unsigned: RTZ -> 0 flags 0x01, RDN -> 0 flags 0x10.
REQ-030 XLEN=64: 0x5F000000 signed -> 0x7FFFFFFFFFFFFFFF flags 0x10; 0xDF000000 signed -> 0x8000000000000000 flags 0x00; 0x00000001 unsigned RUP -> 1 flags 0x01.
REQ-031 i_reset_n low mid-ALIGN with i_request held: o_ready, o_result, o_flags 0 before the next edge; after release 0x40490FDB converts to 3 again.
REQ-032 Handshake: request dropped in ALIGN -> no o_ready, prior result retained; request dropped in PUT_Z -> o_ready 0 one edge later; back-to-back requests each produce one result.
